mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified memory between instruction fetch (IF) and the
//  load/store path driven by the controller's MemRW code. Arbitrates, registers
//  the winning request onto the memory port, waits for mem_ready, returns read
//  data and a one-cycle done pulse to the owner. Sits between core and memory.
// PARAMETERS
//  AW           32  address width (bits)
//  DW           32  data width (bits)
//  STARVE_LIMIT 4   consecutive data grants with if_req pending before IF is forced
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  if_req     in   1   fetch request, held until if_done
//  if_addr    in   AW  fetch address
//  if_done    out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  DW  fetched word, held until next if_done
//  d_memrw    in   2   10=read, 01=write, 00/11=no request; held until d_done
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_done     out  1   one-cycle pulse: access complete, d_rdata valid on reads
//  d_rdata    out  DW  load word, held until next read d_done
//  mem_valid  out  1   memory request active
//  mem_we     out  1   1=write, 0=read
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_ready  in   1   memory accepts/completes access this cycle; rdata valid
//  mem_rdata  in   DW  memory read data
//  busy       out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all outputs 0, starve counter 0.
//    Reset mid-transaction aborts it; no done pulse is issued afterwards.
//  - FSM: IDLE -> BUSY_D | BUSY_I on a grant; BUSY_x -> DONE on mem_ready;
//    DONE -> IDLE unconditionally (1 cycle, done pulse asserted here).
//  - Arbitration in IDLE only: data wins over fetch, except when starve count
//    == STARVE_LIMIT and if_req=1, then fetch wins. d_memrw 11 = no request.
//  - Starve counter: +1 on each data grant while if_req=1 (saturates at limit);
//    cleared on fetch grant or any IDLE cycle with if_req=0.
//  - On grant, mem_valid/mem_we/mem_addr/mem_wdata are registered from the
//    winner (mem_we=1 only for d_memrw=01; mem_wdata=0 for reads) and held
//    stable until mem_ready is sampled high; mem_valid drops the next cycle.
//  - Latency: request seen in IDLE at cycle 0 -> mem_valid high cycle 1 ->
//    mem_ready in cycle k>=1 -> done pulse and rdata in cycle k+1. Minimum 2
//    cycles, next grant earliest cycle k+2.
//  - mem_ready while mem_valid=0 is ignored. Read data captured only on
//    mem_ready of a read; writes leave d_rdata unchanged.
//  - Requester dropping its request mid-transaction does not abort: access
//    completes and the done pulse still fires (requester ignores it).
//  - Request changes during BUSY are not sampled; port fields never change
//    while mem_valid=1.
// TESTING
//  1 Reset: rst_n=0 during BUSY_D with mem_valid=1 -> all outputs 0 that cycle,
//    no d_done after release; release then if_req -> normal fetch.
//  2 Fetch: if_req=1,if_addr=0x100, mem_ready in cycle 1, rdata=0x00500093 ->
//    mem_valid=1,mem_we=0,addr 0x100 cycle 1; if_done=1,if_rdata=0x00500093 cycle 2.
//  3 Store vs fetch: d_memrw=01,d_addr=0x2000,d_wdata=0xDEADBEEF with if_req=1 ->
//    data first, mem_we=1; d_done after mem_ready; d_rdata unchanged; then fetch.
//  4 Starvation: if_req and d_memrw=10 held high continuously, STARVE_LIMIT=4 ->
//    grant order D,D,D,D,I,D,D,D,D,I.
//  5 Wait states: mem_ready low 5 cycles -> port fields stable all 5, single
//    done pulse exactly one cycle after mem_ready, busy low the cycle after.
//  6 Invalid code: d_memrw=11, if_req=0 -> no mem_valid, busy stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// Data wins in IDLE unless fetch has been starved STARVE_LIMIT grants; the winner's request is registered onto the port.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic [1:0]    d_memrw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_d_q, owner_d_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic d_req, d_write, force_if, grant_d, grant_i;

    // Codes 00 and 11 are both "no request"; only 10 and 01 differ in their bits.
    assign d_req    = ^d_memrw;
    assign d_write  = (d_memrw == 2'b01);
    assign force_if = if_req && (starve_q == LIMIT);
    assign grant_d  = (state_q == IDLE) && d_req && !force_if;
    assign grant_i  = (state_q == IDLE) && if_req && !grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = BUSY_D;
                else if (grant_i) state_d = BUSY_I;
            end
            BUSY_D, BUSY_I: begin
                if (mem_ready) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        if_done = (state_q == DONE) && !owner_d_q;
        d_done  = (state_q == DONE) && owner_d_q;
    end

    always_comb begin
        owner_d_d   = owner_d_q;
        starve_d    = starve_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (state_q == IDLE) begin
            if (grant_d && if_req) begin
                if (starve_q != LIMIT) starve_d = starve_q + CW'(1);
            end else if (grant_i || !if_req) begin
                starve_d = '0;
            end
            if (grant_d || grant_i) begin
                owner_d_d   = grant_d;
                mem_valid_d = 1'b1;
                mem_we_d    = grant_d && d_write;
                mem_addr_d  = grant_d ? d_addr : if_addr;
                mem_wdata_d = (grant_d && d_write) ? d_wdata : '0;
            end
        end else if ((state_q == BUSY_D || state_q == BUSY_I) && mem_ready) begin
            mem_valid_d = 1'b0;
            if (!owner_d_q)     if_rdata_d = mem_rdata;
            else if (!mem_we_q) d_rdata_d  = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q   <= 1'b0;
            starve_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            owner_d_q   <= owner_d_d;
            starve_q    <= starve_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic [1:0]  d_memrw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_d_rdata  = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_memrw(d_memrw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_data, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.is_data = is_data; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Called in a negedge slot; returns in the negedge slot of the IDLE cycle after done.
    task automatic service(input int waits);
        txn_t e;
        int n = 0;
        logic [31:0] a0, w0;
        logic we0;
        while (!mem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", {31'h0, mem_valid}, 32'h1);
        if (!mem_valid || sb.size() == 0) begin
            check("sb_nonempty", sb.size(), 32'h1);
            return;
        end
        e = sb.pop_front();
        check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
        a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_valid", {31'h0, mem_valid}, 32'h1);
            check("wait_addr", mem_addr, a0);
            check("wait_wdata", mem_wdata, w0);
            check("wait_we", {31'h0, mem_we}, {31'h0, we0});
            check("wait_no_done", {30'h0, if_done, d_done}, 32'h0);
        end
        mem_ready = 1'b1;
        mem_rdata = e.rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        if (e.is_data && !e.we) exp_d_rdata = e.rdata;
        if (!e.is_data) exp_if_rdata = e.rdata;
        check("valid_dropped", {31'h0, mem_valid}, 32'h0);
        check("if_done", {31'h0, if_done}, {31'h0, !e.is_data});
        check("d_done", {31'h0, d_done}, {31'h0, e.is_data});
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_no_done", {30'h0, if_done, d_done}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_memrw = 2'b00;
        d_addr = 32'h0; d_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {27'h0, mem_valid, mem_we, busy, if_done, d_done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a data read.
        d_memrw = 2'b10; d_addr = 32'h0000_4000;
        @(negedge clk);
        d_memrw = 2'b00;
        check("pre_rst_valid", {31'h0, mem_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {27'h0, mem_valid, mem_we, busy, if_done, d_done}, 32'h0);
        check("rst_mid_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {29'h0, mem_valid, busy, d_done}, 32'h0);
        end
        mem_ready = 1'b0;

        // Plain fetch, zero wait states.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        push(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0050_0093);
        @(negedge clk);
        service(0);
        if_req = 1'b0;
        @(negedge clk);

        // Store with a fetch pending: data first, then fetch.
        d_memrw = 2'b01; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0104;
        push(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h7777_7777);
        push(1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h0010_0113);
        @(negedge clk);
        service(1);
        d_memrw = 2'b00;
        service(0);
        if_req = 1'b0;
        @(negedge clk);

        // Starvation: both requesters held continuously.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_memrw = 2'b10; d_addr = 32'h0000_3000;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) push(1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'hF000_0000 + g);
            else                  push(1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hD000_0000 + g);
        end
        @(negedge clk);
        for (int g = 0; g < 10; g++) service(0);
        if_req = 1'b0; d_memrw = 2'b00;
        @(negedge clk);

        // Five wait states on a load.
        d_memrw = 2'b10; d_addr = 32'h0000_5004;
        push(1'b1, 1'b0, 32'h0000_5004, 32'h0, 32'h1234_5678);
        @(negedge clk);
        service(5);
        d_memrw = 2'b00;

        // Code 11 is no request; stray mem_ready is ignored.
        d_memrw = 2'b11; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("invalid_code", {30'h0, mem_valid, busy}, 32'h0);
        end
        check("invalid_d_rdata", d_rdata, exp_d_rdata);
        d_memrw = 2'b00; mem_ready = 1'b0;
        check("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
